// File: rtl/braid_flow_sequencer.sv
// braid_flow_sequencer: valve sequencer for one N_IN x DEPTH mixer braid.
// It doses the requested inlets one at a time in round-robin order, with a
// closed guard gap after every dose. It then waits out the mixing chain and
// drains through the outlets. All outputs are registered, and reset closes
// every valve asynchronously.
module braid_flow_sequencer #(
    parameter int N_IN         = 8,
    parameter int DEPTH        = 8,
    parameter int STAGE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int DOSE_W       = 8,
    parameter int RND_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_IN-1:0]   req,
    input  logic [DOSE_W-1:0] dose_len,
    input  logic              abort,
    output logic [N_IN-1:0]   inlet_valve,
    output logic [N_IN-1:0]   outlet_valve,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [RND_W-1:0]  round_cnt
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Phase lengths. Zero-length phases still occupy one cycle, so the
    // closed guard cycle between doses always exists.
    localparam int MIX_CYC = imax(DEPTH * STAGE_CYCLES, 1);
    localparam int GAP_CYC = imax(GAP_CYCLES, 1);
    localparam int DRN_CYC = imax(DRAIN_CYCLES, 1);
    localparam int CNT_MAX = imax(imax(2 ** DOSE_W, DEPTH * STAGE_CYCLES),
                                  imax(GAP_CYCLES, DRAIN_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [CNT_W-1:0] MIX_LD = CNT_W'(MIX_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] DRN_LD = CNT_W'(DRN_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_IN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DOSE  = 3'd1,
        S_GAP   = 3'd2,
        S_MIX   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state_q;
    logic [N_IN-1:0]   pend_q;
    logic [DOSE_W-1:0] dl_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PTR_W-1:0]  rr_q;
    logic [PTR_W-1:0]  g_q;
    logic [N_IN-1:0]   inlet_q;
    logic [N_IN-1:0]   outlet_q;
    logic              busy_q;
    logic              done_q;
    logic              aborted_q;
    logic [RND_W-1:0]  round_q;

    logic [DOSE_W-1:0] dl_d;
    logic [N_IN-1:0]   srch_mask;
    logic [PTR_W-1:0]  grant;
    logic [PTR_W-1:0]  idx;
    logic [PTR_W-1:0]  rr_d;

    // A dose length of zero is stretched to one cycle.
    always_comb begin
        dl_d = (dose_len == '0) ? DOSE_W'(1) : dose_len;
    end

    // Round-robin grant: the first pending inlet at or above rr_q, wrapping.
    // In IDLE the search runs over the incoming req, so the first valve can
    // open on the same edge that accepts start.
    always_comb begin
        srch_mask = (state_q == S_IDLE) ? req : pend_q;
        grant     = '0;
        idx       = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(rr_q) + i) % N_IN);
            if (srch_mask[idx]) grant = idx;
        end
    end

    // The pointer moves just past the inlet that was served.
    always_comb begin
        rr_d = (g_q == PTR_LAST) ? '0 : g_q + 1'b1;
    end

    // Main sequencer. Valve, busy and pulse outputs are registered here
    // alongside the state, so they always change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            dl_q      <= '0;
            cnt_q     <= '0;
            rr_q      <= '0;
            g_q       <= '0;
            inlet_q   <= '0;
            outlet_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            round_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                // Cancel: close everything and drop pending work. The round
                // counter and the fairness pointer are left as they are.
                state_q   <= S_IDLE;
                pend_q    <= '0;
                cnt_q     <= '0;
                inlet_q   <= '0;
                outlet_q  <= '0;
                busy_q    <= 1'b0;
                aborted_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            dl_q <= dl_d;
                            if (req == '0) begin
                                pend_q  <= '0;
                                done_q  <= 1'b1;
                                round_q <= round_q + 1'b1;
                            end else begin
                                pend_q  <= req;
                                g_q     <= grant;
                                inlet_q <= N_IN'(1) << grant;
                                cnt_q   <= CNT_W'(dl_d) - 1'b1;
                                busy_q  <= 1'b1;
                                state_q <= S_DOSE;
                            end
                        end
                    end
                    S_DOSE: begin
                        if (cnt_q == '0) begin
                            inlet_q     <= '0;
                            pend_q[g_q] <= 1'b0;
                            rr_q        <= rr_d;
                            cnt_q       <= GAP_LD;
                            state_q     <= S_GAP;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (cnt_q == '0) begin
                            if (pend_q != '0) begin
                                g_q     <= grant;
                                inlet_q <= N_IN'(1) << grant;
                                cnt_q   <= CNT_W'(dl_q) - 1'b1;
                                state_q <= S_DOSE;
                            end else begin
                                cnt_q   <= MIX_LD;
                                state_q <= S_MIX;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_MIX: begin
                        if (cnt_q == '0) begin
                            outlet_q <= '1;
                            cnt_q    <= DRN_LD;
                            state_q  <= S_DRAIN;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (cnt_q == '0) begin
                            outlet_q <= '0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            round_q  <= round_q + 1'b1;
                            state_q  <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        inlet_q  <= '0;
                        outlet_q <= '0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign inlet_valve  = inlet_q;
    assign outlet_valve = outlet_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign round_cnt    = round_q;

endmodule
